// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter: width math,
// FSM state encoding and packed-bus slice offsets.
package regfile_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // A single requester still needs a 1-bit pointer register.
  function automatic int ptrWidth(input int reqs);
    return (reqs > 1) ? clog2(reqs) : 1;
  endfunction

  function automatic int sliceLsb(input int slot, input int width);
    return slot * width;
  endfunction

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side and register-file-side buses of the write arbiter.
// The arbiter is the slave; the writeback sources plus register file form the master.
interface regfile_write_arbiter_if #(
  parameter int REQS   = 4,
  parameter int WRITES = 1,
  parameter int WIDTH  = 32,
  parameter int N      = 5
);
  logic                    hold;
  logic [REQS-1:0]         req_valid;
  logic [REQS*N-1:0]       req_index;
  logic [REQS*WIDTH-1:0]   req_data;
  logic [REQS-1:0]         req_ready;
  logic [WRITES-1:0]       wr_en;
  logic [WRITES*N-1:0]     wr_index;
  logic [WRITES*WIDTH-1:0] wr_data;
  logic                    busy;

  modport master (
    output hold, req_valid, req_index, req_data,
    input  req_ready, wr_en, wr_index, wr_data, busy
  );

  modport slave (
    input  hold, req_valid, req_index, req_data,
    output req_ready, wr_en, wr_index, wr_data, busy
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_grant_scan.sv
// Combinational round-robin scan: starting at ptr, grants up to WRITES valid
// requesters whose indices are pairwise distinct, assigning ports in scan order.
module rr_grant_scan
  import regfile_pkg::*;
#(
  parameter int REQS   = 4,
  parameter int WRITES = 1,
  parameter int N      = 5,
  parameter int PW     = ptrWidth(REQS)
) (
  input  logic                 enable,
  input  logic [PW-1:0]        ptr,
  input  logic [REQS-1:0]      valid,
  input  logic [REQS*N-1:0]    indices,
  output logic [REQS-1:0]      grant,
  output logic [WRITES-1:0]    portValid,
  output logic [WRITES*PW-1:0] portSel,
  output logic                 anyGrant,
  output logic [PW-1:0]        lastGrant
);

  always_comb begin
    int   count;
    int   slot;
    logic clash;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant     = '0;
    portValid = '0;
    portSel   = '0;
    lastGrant = ptr;
    count     = 0;
    for (int k = 0; k < REQS; k++) begin
      slot  = (int'(ptr) + k) % REQS;
      clash = 1'b0;
      for (int j = 0; j < REQS; j++) begin
        if (grant[j] && (indices[sliceLsb(j, N) +: N] == indices[sliceLsb(slot, N) +: N]))
          clash = 1'b1;
      end
      if (enable && valid[slot] && (count < WRITES) && !clash) begin
        grant[slot]                      = 1'b1;
        portValid[count]                 = 1'b1;
        portSel[sliceLsb(count, PW) +: PW] = PW'(slot);
        lastGrant                        = PW'(slot);
        count++;
      end
    end
    anyGrant = |grant;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write ports among writeback
// sources; holds off grants for INIT_CYCLES after reset while the file reloads.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int REQS        = 4,
  parameter int WRITES      = 1,
  parameter int WIDTH       = 32,
  parameter int N           = 5,
  parameter int INIT_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int            PW        = ptrWidth(REQS);
  localparam int            CW        = (INIT_CYCLES > 1) ? clog2(INIT_CYCLES) : 1;
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(REQS - 1);

  state_t                state;
  logic [CW-1:0]         initCnt;
  logic [PW-1:0]         ptr;
  logic                  scanEnable;
  logic [REQS-1:0]       grant;
  logic [WRITES-1:0]     portValid;
  logic [WRITES*PW-1:0]  portSel;
  logic                  anyGrant;
  logic [PW-1:0]         lastGrant;
  logic [WRITES*N-1:0]     portIndex;
  logic [WRITES*WIDTH-1:0] portData;

  assign scanEnable = (state == RUN) && !bus.hold;

  rr_grant_scan #(
    .REQS  (REQS),
    .WRITES(WRITES),
    .N     (N),
    .PW    (PW)
  ) u_scan (
    .enable   (scanEnable),
    .ptr      (ptr),
    .valid    (bus.req_valid),
    .indices  (bus.req_index),
    .grant    (grant),
    .portValid(portValid),
    .portSel  (portSel),
    .anyGrant (anyGrant),
    .lastGrant(lastGrant)
  );

  assign bus.req_ready = grant;
  assign bus.busy      = (state == INIT);

  // Route each port's selected requester onto the port-ordered buses.
  always_comb begin
    portIndex = '0;
    portData  = '0;
    for (int k = 0; k < WRITES; k++) begin
      portIndex[sliceLsb(k, N) +: N] =
        bus.req_index[sliceLsb(int'(portSel[sliceLsb(k, PW) +: PW]), N) +: N];
      portData[sliceLsb(k, WIDTH) +: WIDTH] =
        bus.req_data[sliceLsb(int'(portSel[sliceLsb(k, PW) +: PW]), WIDTH) +: WIDTH];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      initCnt      <= '0;
      ptr          <= '0;
      bus.wr_en    <= '0;
      bus.wr_index <= '0;
      bus.wr_data  <= '0;
    end else begin
      if (state == INIT) begin
        if (initCnt == INIT_LAST) state <= RUN;
        else                      initCnt <= initCnt + 1'b1;
      end
      if (anyGrant) ptr <= (lastGrant == PTR_LAST) ? '0 : lastGrant + 1'b1;
      bus.wr_en <= portValid;
      // Idle ports keep their last index/data so the file's buses do not toggle.
      for (int k = 0; k < WRITES; k++) begin
        if (portValid[k]) begin
          bus.wr_index[sliceLsb(k, N) +: N]         <= portIndex[sliceLsb(k, N) +: N];
          bus.wr_data[sliceLsb(k, WIDTH) +: WIDTH]  <= portData[sliceLsb(k, WIDTH) +: WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Drives a one-port and a two-port arbiter side by side with directed and random
// requester traffic and compares both against a behavioural grant model.
module tb_regfile_write_arbiter;

  localparam int REQS     = 4;
  localparam int WIDTH    = 32;
  localparam int N        = 5;
  localparam int INIT_CYC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.REQS(REQS), .WRITES(1), .WIDTH(WIDTH), .N(N)) bus0 ();
  regfile_write_arbiter_if #(.REQS(REQS), .WRITES(2), .WIDTH(WIDTH), .N(N)) bus1 ();

  regfile_write_arbiter #(.REQS(REQS), .WRITES(1), .WIDTH(WIDTH), .N(N), .INIT_CYCLES(INIT_CYC))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  regfile_write_arbiter #(.REQS(REQS), .WRITES(2), .WIDTH(WIDTH), .N(N), .INIT_CYCLES(INIT_CYC))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Requester state per arbiter instance (d = 0: one port, d = 1: two ports).
  logic             holdIn;
  logic             rv[2][REQS];
  logic [N-1:0]     ri[2][REQS];
  logic [WIDTH-1:0] rd[2][REQS];

  // Reference model state.
  int               mPtr[2];
  int               sinceRel[2];
  int               gCount[2];
  int               gReq[2][2];
  logic [REQS-1:0]  expReady[2];
  logic             expEn[2][2];
  logic [N-1:0]     expIdx[2][2];
  logic [WIDTH-1:0] expData[2][2];
  int               writesExp[2];
  int               writesObs[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQS-1:0] obsReady(input int d);
    return (d == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  function automatic logic obsBusy(input int d);
    return (d == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic obsEn(input int d, input int p);
    return (d == 0) ? bus0.wr_en[0] : bus1.wr_en[p];
  endfunction

  function automatic logic [N-1:0] obsIdx(input int d, input int p);
    return (d == 0) ? bus0.wr_index[N-1:0] : bus1.wr_index[p*N +: N];
  endfunction

  function automatic logic [WIDTH-1:0] obsData(input int d, input int p);
    return (d == 0) ? bus0.wr_data[WIDTH-1:0] : bus1.wr_data[p*WIDTH +: WIDTH];
  endfunction

  task automatic drive();
    for (int i = 0; i < REQS; i++) begin
      bus0.req_valid[i]              = rv[0][i];
      bus0.req_index[i*N +: N]       = ri[0][i];
      bus0.req_data[i*WIDTH +: WIDTH] = rd[0][i];
      bus1.req_valid[i]              = rv[1][i];
      bus1.req_index[i*N +: N]       = ri[1][i];
      bus1.req_data[i*WIDTH +: WIDTH] = rd[1][i];
    end
    bus0.hold = holdIn;
    bus1.hold = holdIn;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mPtr[d]     = 0;
      sinceRel[d] = 0;
      for (int p = 0; p < 2; p++) begin
        expEn[d][p]   = 1'b0;
        expIdx[d][p]  = '0;
        expData[d][p] = '0;
      end
      for (int i = 0; i < REQS; i++) rv[d][i] = 1'b0;
    end
  endtask

  // Walk requesters from the pointer, taking each valid one whose index is not
  // already taken this cycle, until the port budget (d+1) is used up.
  task automatic computeGrants(input int d);
    logic [N-1:0] taken[$];
    int           r;
    bit           dup;
    expReady[d] = '0;
    gCount[d]   = 0;
    if (rst_n && (sinceRel[d] >= INIT_CYC) && !holdIn) begin
      for (int k = 0; k < REQS; k++) begin
        r   = (mPtr[d] + k) % REQS;
        dup = 1'b0;
        foreach (taken[t]) if (taken[t] == ri[d][r]) dup = 1'b1;
        if (rv[d][r] && (taken.size() < d + 1) && !dup) begin
          taken.push_back(ri[d][r]);
          expReady[d][r]     = 1'b1;
          gReq[d][gCount[d]] = r;
          gCount[d]++;
        end
      end
    end
  endtask

  task automatic advance(input int d);
    for (int p = 0; p < d + 1; p++) begin
      if (p < gCount[d]) begin
        expEn[d][p]   = 1'b1;
        expIdx[d][p]  = ri[d][gReq[d][p]];
        expData[d][p] = rd[d][gReq[d][p]];
        writesExp[d]++;
      end else begin
        expEn[d][p] = 1'b0;
      end
    end
    if (gCount[d] > 0) mPtr[d] = (gReq[d][gCount[d]-1] + 1) % REQS;
    if (rst_n) sinceRel[d]++;
    for (int i = 0; i < REQS; i++) if (expReady[d][i]) rv[d][i] = 1'b0;
  endtask

  // One clock: check grants before the edge, registered outputs just after it.
  task automatic cycle();
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      computeGrants(d);
      chk($sformatf("ready%0d", d), 64'(obsReady(d)), 64'(expReady[d]));
      chk($sformatf("busy%0d", d), 64'(obsBusy(d)), 64'(sinceRel[d] < INIT_CYC));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      advance(d);
      for (int p = 0; p < d + 1; p++) begin
        chk($sformatf("wr_en%0d_%0d", d, p), 64'(obsEn(d, p)), 64'(expEn[d][p]));
        chk($sformatf("wr_index%0d_%0d", d, p), 64'(obsIdx(d, p)), 64'(expIdx[d][p]));
        chk($sformatf("wr_data%0d_%0d", d, p), 64'(obsData(d, p)), 64'(expData[d][p]));
        if (obsEn(d, p)) writesObs[d]++;
      end
    end
    if (bus1.wr_en == 2'b11)
      chk("distinct_ports", 64'(bus1.wr_index[N-1:0] != bus1.wr_index[2*N-1:N]), 64'(1));
  endtask

  task automatic refillDistinct();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < REQS; i++)
        if (!rv[d][i]) begin
          rv[d][i] = 1'b1;
          ri[d][i] = N'(i + 1);
          rd[d][i] = $urandom;
        end
  endtask

  task automatic refillRandom();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < REQS; i++)
        if (!rv[d][i] && ($urandom % 100 < 60)) begin
          rv[d][i] = 1'b1;
          ri[d][i] = N'($urandom % 4);
          rd[d][i] = $urandom;
        end
  endtask

  initial begin
    holdIn = 1'b0;
    writesExp = '{0, 0};
    writesObs = '{0, 0};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < REQS; i++) begin
        ri[d][i] = '0;
        rd[d][i] = '0;
      end
    modelReset();

    // Reset state, then INIT with every requester valid on distinct indices.
    refillDistinct();
    drive();
    #1;
    chk("rst_ready0", 64'(bus0.req_ready), 64'(0));
    chk("rst_ready1", 64'(bus1.req_ready), 64'(0));
    chk("rst_busy0", 64'(bus0.busy), 64'(1));
    chk("rst_wr_en1", 64'(bus1.wr_en), 64'(0));
    chk("rst_wr_index1", 64'(bus1.wr_index), 64'(0));
    chk("rst_wr_data0", 64'(bus0.wr_data), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    cycle();
    drive();
    #1;
    chk("init_first_grant", 64'(bus0.req_ready), 64'(4'b0001));

    // One port, all valid: strict rotation 0,1,2,3,0.
    for (int s = 0; s < 5; s++) begin
      refillDistinct();
      drive();
      #1;
      chk($sformatf("rotate_grant_%0d", s), 64'(bus0.req_ready), 64'(4'b0001 << (s % 4)));
      cycle();
      chk($sformatf("rotate_wr_en_%0d", s), 64'(bus0.wr_en), 64'(1));
    end

    // Hold for three cycles, then resume from the same pointer (requester 1).
    holdIn = 1'b1;
    for (int s = 0; s < 3; s++) begin
      refillDistinct();
      cycle();
      chk($sformatf("hold_wr_en_%0d", s), 64'(bus0.wr_en), 64'(0));
    end
    holdIn = 1'b0;
    refillDistinct();
    drive();
    #1;
    chk("hold_resume", 64'(bus0.req_ready), 64'(4'b0010));
    cycle();
    chk("pre_reset_wr_en", 64'(bus0.wr_en), 64'(1));

    // Asynchronous reset between clock edges clears the write outputs at once.
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("async_wr_en0", 64'(bus0.wr_en), 64'(0));
    chk("async_wr_en1", 64'(bus1.wr_en), 64'(0));
    chk("async_busy1", 64'(bus1.busy), 64'(1));
    chk("async_wr_index0", 64'(bus0.wr_index), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Index conflict on the two-port arbiter: req0/req1 both index 7, req2 index 3.
    for (int d = 0; d < 2; d++) begin
      rv[d][0] = 1'b1; ri[d][0] = N'(7); rd[d][0] = $urandom;
      rv[d][1] = 1'b1; ri[d][1] = N'(7); rd[d][1] = $urandom;
      rv[d][2] = 1'b1; ri[d][2] = N'(3); rd[d][2] = $urandom;
      rv[d][3] = 1'b0; ri[d][3] = '0;    rd[d][3] = '0;
    end
    cycle();
    cycle();
    drive();
    #1;
    chk("conflict_pair", 64'(bus1.req_ready), 64'(4'b0101));
    cycle();
    chk("conflict_both_ports", 64'(bus1.wr_en), 64'(2'b11));
    chk("conflict_port1_idx", 64'(bus1.wr_index[2*N-1:N]), 64'(3));
    drive();
    #1;
    chk("conflict_retry", 64'(bus1.req_ready), 64'(4'b0010));
    cycle();
    chk("conflict_retry_en", 64'(bus1.wr_en), 64'(2'b01));
    chk("conflict_retry_idx", 64'(bus1.wr_index[N-1:0]), 64'(7));

    // Random traffic with frequent index collisions and occasional hold.
    for (int s = 0; s < 400; s++) begin
      holdIn = ($urandom % 10 == 0);
      refillRandom();
      cycle();
    end
    holdIn = 1'b0;
    chk("writes_total0", 64'(writesObs[0]), 64'(writesExp[0]));
    chk("writes_total1", 64'(writesObs[1]), 64'(writesExp[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
